hazard_pipeline_tracker: RTL and testbench

Producer side of the operand-forwarding interface. Tracks destination-register and control fields of in-flight instructions through the ID/EX, EX/MEM and MEM/WB stages, and drives the forwarding unit's rd/regwrite/rs/rt inputs from those registered stage fields. Detects load-use hazards and inserts exactly one bubble per hazard. Freezes on memory busy and squashes on branch flush. Sits between decode and the forwarding/execute logic of the 5-stage core.

---
 rtl/hazard_pipeline_tracker.sv | 111 +++++++++++
 tb/tb_hazard_pipeline_tracker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_pipeline_tracker.sv
// Hazard and pipeline tracker: the producer side of the operand-forwarding interface.
// It carries the destination and control fields of in-flight instructions through the
// ID/EX, EX/MEM and MEM/WB stage registers. It detects load-use hazards and inserts one
// bubble for each. It freezes on mem_busy and squashes the decode slot on flush.
// Ports:
//   clk, reset                      - clock; synchronous active-high reset
//   id_valid, if_id_register_rs/rt  - decode-slot validity and source registers
//   id_register_rd, id_regwrite,
//   id_memread                      - decode-slot destination and control
//   flush, mem_busy                 - branch squash; whole-pipeline hold
//   id_ex_*, ex_mem_*, mem_wb_*     - registered stage fields to the forwarding unit
//   pc_write, if_id_write           - front-end advance enables (combinational)
//   id_ex_bubble                    - bubble entering ID/EX this cycle (combinational)
//   stall_count                     - saturating count of cycles with pc_write=0
module hazard_pipeline_tracker #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] if_id_register_rs,
    input  logic [REG_ADDR_W-1:0] if_id_registerrt,
    input  logic [REG_ADDR_W-1:0] id_register_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    input  logic                  mem_busy,
    output logic [REG_ADDR_W-1:0] id_ex_register_rs,
    output logic [REG_ADDR_W-1:0] id_ex_registerrt,
    output logic [REG_ADDR_W-1:0] id_ex_register_rd,
    output logic                  id_ex_regwrite,
    output logic                  id_ex_memread,
    output logic [REG_ADDR_W-1:0] ex_mem_register_rd,
    output logic                  ex_mem_regwrite,
    output logic [REG_ADDR_W-1:0] mem_wb_register_rd,
    output logic                  mem_wb_regwrite,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic [COUNT_W-1:0]    stall_count
);

    logic load_use;

    // A load in EX whose non-zero destination feeds the valid decode instruction.
    always_comb begin
        load_use = id_ex_memread && id_ex_regwrite
                && (id_ex_register_rd != REG_ADDR_W'(0)) && id_valid
                && ((id_ex_register_rd == if_id_register_rs)
                 || (id_ex_register_rd == if_id_registerrt));
    end

    // Front-end control. mem_busy outranks flush, and flush outranks load_use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (flush) begin
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Stage registers and the stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_register_rs  <= '0;
            id_ex_registerrt   <= '0;
            id_ex_register_rd  <= '0;
            id_ex_regwrite     <= 1'b0;
            id_ex_memread      <= 1'b0;
            ex_mem_register_rd <= '0;
            ex_mem_regwrite    <= 1'b0;
            mem_wb_register_rd <= '0;
            mem_wb_regwrite    <= 1'b0;
            stall_count        <= '0;
        end else begin
            if (!mem_busy) begin
                mem_wb_register_rd <= ex_mem_register_rd;
                mem_wb_regwrite    <= ex_mem_regwrite;
                ex_mem_register_rd <= id_ex_register_rd;
                ex_mem_regwrite    <= id_ex_regwrite;
                if (id_ex_bubble) begin
                    id_ex_register_rs <= '0;
                    id_ex_registerrt  <= '0;
                    id_ex_register_rd <= '0;
                    id_ex_regwrite    <= 1'b0;
                    id_ex_memread     <= 1'b0;
                end else begin
                    id_ex_register_rs <= if_id_register_rs;
                    id_ex_registerrt  <= if_id_registerrt;
                    id_ex_register_rd <= id_register_rd;
                    id_ex_regwrite    <= id_regwrite && id_valid;
                    id_ex_memread     <= id_memread && id_valid;
                end
            end
            // The counter saturates at all-ones and never wraps.
            if (!pc_write && (stall_count != {COUNT_W{1'b1}})) begin
                stall_count <= stall_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_pipeline_tracker.sv
// Scoreboard bench for hazard_pipeline_tracker. The stimulus process pushes expected
// values from a stage-array reference model. A separate monitor pops them and compares
// them against the DUT every cycle.
module tb_hazard_pipeline_tracker;

    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 3;
    localparam int          SMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] if_id_register_rs, if_id_registerrt, id_register_rd;
    logic          id_regwrite, id_memread, flush, mem_busy;
    logic [AW-1:0] id_ex_register_rs, id_ex_registerrt, id_ex_register_rd;
    logic          id_ex_regwrite, id_ex_memread;
    logic [AW-1:0] ex_mem_register_rd, mem_wb_register_rd;
    logic          ex_mem_regwrite, mem_wb_regwrite;
    logic          pc_write, if_id_write, id_ex_bubble;
    logic [CW-1:0] stall_count;

    hazard_pipeline_tracker #(.REG_ADDR_W(AW), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .if_id_register_rs(if_id_register_rs), .if_id_registerrt(if_id_registerrt),
        .id_register_rd(id_register_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .mem_busy(mem_busy),
        .id_ex_register_rs(id_ex_register_rs), .id_ex_registerrt(id_ex_registerrt),
        .id_ex_register_rd(id_ex_register_rd), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_memread(id_ex_memread), .ex_mem_register_rd(ex_mem_register_rd),
        .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_register_rd(mem_wb_register_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] rs, rt, rd;
        logic          rw, mr;
    } instr_t;

    typedef struct {
        instr_t        ie, em, mw;
        logic          pw, ifw, bub;
        logic [CW-1:0] sc;
    } exp_t;

    // Model: pipe[0]=ID/EX, pipe[1]=EX/MEM, pipe[2]=MEM/WB.
    instr_t pipe [3];
    int     stalls;
    exp_t   q [$];
    int     total = 0;
    int     bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Drive one cycle of decode inputs, push the expected outputs, and advance the model.
    task automatic step(input logic v, input int rs, input int rt, input int rd,
                        input logic w, input logic m, input logic f,
                        input logic mb, input logic r);
        exp_t   e;
        instr_t nw;
        logic   hz;
        @(negedge clk);
        reset = r; id_valid = v; flush = f; mem_busy = mb;
        if_id_register_rs = AW'(rs); if_id_registerrt = AW'(rt);
        id_register_rd = AW'(rd); id_regwrite = w; id_memread = m;
        hz = pipe[0].mr && pipe[0].rw && (pipe[0].rd != 0) && v
          && (pipe[0].rd == AW'(rs) || pipe[0].rd == AW'(rt));
        e.ie = pipe[0]; e.em = pipe[1]; e.mw = pipe[2];
        e.sc = CW'(stalls);
        e.pw  = !(mb || (!f && hz));
        e.ifw = e.pw;
        e.bub = !mb && (f || hz);
        q.push_back(e);
        if (r) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            stalls = 0;
        end else begin
            if (!e.pw && stalls < SMAX) stalls++;
            if (!mb) begin
                nw = e.bub ? instr_t'('0)
                           : '{rs: AW'(rs), rt: AW'(rt), rd: AW'(rd), rw: w && v, mr: m && v};
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = nw;
            end
        end
    endtask

    // Monitor: wait until the inputs have settled, then compare against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("id_ex_rs",   32'(id_ex_register_rs),  32'(e.ie.rs));
                chk("id_ex_rt",   32'(id_ex_registerrt),   32'(e.ie.rt));
                chk("id_ex_rd",   32'(id_ex_register_rd),  32'(e.ie.rd));
                chk("id_ex_rw",   32'(id_ex_regwrite),     32'(e.ie.rw));
                chk("id_ex_mr",   32'(id_ex_memread),      32'(e.ie.mr));
                chk("ex_mem_rd",  32'(ex_mem_register_rd), 32'(e.em.rd));
                chk("ex_mem_rw",  32'(ex_mem_regwrite),    32'(e.em.rw));
                chk("mem_wb_rd",  32'(mem_wb_register_rd), 32'(e.mw.rd));
                chk("mem_wb_rw",  32'(mem_wb_regwrite),    32'(e.mw.rw));
                chk("pc_write",   32'(pc_write),           32'(e.pw));
                chk("if_id_write",32'(if_id_write),        32'(e.ifw));
                chk("bubble",     32'(id_ex_bubble),       32'(e.bub));
                chk("stall_count",32'(stall_count),        32'(e.sc));
            end
        end
    end

    initial begin
        reset = 1'b1; id_valid = 1'b0; flush = 1'b0; mem_busy = 1'b0;
        if_id_register_rs = '0; if_id_registerrt = '0; id_register_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        stalls = 0;
        repeat (2) @(posedge clk);

        // Reset state while reset is held.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load rd=5, then a dependent instruction: one stall, then it enters.
        step(1, 1, 2, 5, 1, 1, 0, 0, 0);
        step(1, 5, 6, 7, 1, 0, 0, 0, 0);
        step(1, 5, 6, 7, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU chain: no stall; rd=3 moves down the pipeline.
        step(1, 1, 2, 3, 1, 0, 0, 0, 0);
        step(1, 3, 4, 9, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // A load to $0 never stalls.
        step(1, 1, 1, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0, 0);
        // Freeze with 9/8/7 in the stages, held for 3 cycles, then release.
        step(1, 0, 0, 7, 1, 0, 0, 0, 0);
        step(1, 0, 0, 8, 1, 0, 0, 0, 0);
        step(1, 0, 0, 9, 1, 0, 0, 0, 0);
        repeat (3) step(1, 1, 1, 1, 1, 0, 0, 1, 0);
        step(1, 1, 1, 1, 1, 0, 0, 0, 0);
        // Flush outranks load_use.
        step(1, 1, 2, 5, 1, 1, 0, 0, 0);
        step(1, 5, 5, 6, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Ten load-use stalls drive the 3-bit counter into saturation.
        for (int k = 0; k < 10; k++) begin
            step(1, 0, 0, 4, 1, 1, 0, 0, 0);
            step(1, 2, 4, 6, 1, 0, 0, 0, 0);
        end
        step(1, 2, 4, 6, 1, 0, 0, 0, 0);
        // Reset during an active stall.
        step(1, 0, 0, 4, 1, 1, 0, 0, 0);
        step(1, 4, 0, 6, 1, 0, 0, 0, 1);
        step(1, 4, 0, 6, 1, 0, 0, 0, 0);
        // Randomized traffic over a small register set, so hazards are frequent.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 49) == 0);
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
